// File: rtl/chdr_traffic_source.sv
// chdr_traffic_source
//   CHDR packet generator for one crossbar ingress port. Each packet is a
//   header line, a timestamp line and (lpp-2) incrementing payload lines.
//   Lines are paced by a credit accumulator that follows injection_rate.
//   The destination comes from the selected traffic pattern.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   current_time          free-running time, sampled for the timestamp line
//   start_stb / stop_stb  begin a session / end it after the current packet
//   num_pkts              packets per session (0 = until stop_stb)
//   injection_rate        lines per 100 cycles (clamped to 100)
//   lines_per_pkt         lines per packet (clamped to 3..2^MTU)
//   traffic_patt          ASCII 'U','N','L','B' (anything else acts as 'L')
//   m_axis_*              AXI-Stream master carrying CHDR lines
//   session_active        high while a session is running
//   xfer_count, pkt_count line / packet handshakes in this session
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no session; wait for start_stb
// S_HDR     | next line to load is a header (or the last payload is in flight)
// S_TIME    | header loaded; next line to load is the timestamp
// S_PAYLOAD | loading payload lines 0..lpp-3
module chdr_traffic_source #(
    parameter int          WIDTH     = 64,
    parameter int          MTU       = 5,
    parameter logic [15:0] NODE_ID   = 16'd0,
    parameter logic [15:0] NUM_NODES = 16'd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] current_time,
    input  logic             start_stb,
    input  logic [31:0]      num_pkts,
    input  logic             stop_stb,
    input  logic [7:0]       injection_rate,
    input  logic [15:0]      lines_per_pkt,
    input  logic [7:0]       traffic_patt,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             session_active,
    output logic [31:0]      xfer_count,
    output logic [31:0]      pkt_count
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_TIME, S_PAYLOAD} state_t;

    localparam logic [15:0] NODE_MASK     = NUM_NODES - 16'd1;
    localparam logic [15:0] LPP_MAX       = 16'(1 << MTU);
    localparam logic [15:0] LFSR_SEED_RAW = NODE_ID ^ 16'hACE1;
    localparam logic [15:0] LFSR_SEED     = (LFSR_SEED_RAW == 16'd0) ? 16'h0001 : LFSR_SEED_RAW;

    state_t           state;
    logic [11:0]      seqnum;
    logic [7:0]       acc;
    logic [15:0]      lfsr;
    logic [WIDTH-1:0] ts;
    logic [15:0]      pay_idx;
    logic             hdr_out;      // the line on the bus is a header
    logic             stop_pend;
    logic [7:0]       rate_q;
    logic [15:0]      lpp_q;
    logic [7:0]       patt_q;
    logic [31:0]      num_pkts_q;

    logic        hs;
    logic        last_hs;
    logic        can_load;
    logic        credit_ok;
    logic        limit_hit;
    logic        ending;
    logic        idle_stop;
    logic        last_pay;
    logic [8:0]  acc_sum;
    logic [7:0]  acc_next;
    logic [7:0]  rate_in;
    logic [15:0] lpp_in;
    logic [15:0] lfsr_step;
    logic [15:0] dst_next;
    logic [15:0] lpp_bytes;
    logic [63:0] hdr_line;
    logic [63:0] pay_line;

    always_comb begin
        hs       = m_axis_tvalid & m_axis_tready;
        last_hs  = hs & m_axis_tlast;
        can_load = !m_axis_tvalid || hs;

        // Net credit after this cycle's add and any handshake, then capped.
        acc_sum = {1'b0, acc} + {1'b0, rate_q};
        if (hs) begin
            acc_sum = acc_sum - 9'd100;
        end
        acc_next  = (acc_sum > 9'd200) ? 8'd200 : acc_sum[7:0];
        credit_ok = (acc_next >= 8'd100);

        limit_hit = (num_pkts_q != 32'd0) && ((pkt_count + 32'd1) == num_pkts_q);
        ending    = last_hs && (limit_hit || stop_pend || stop_stb);
        idle_stop = (stop_stb || stop_pend) && (state == S_HDR) && !m_axis_tvalid;
        last_pay  = (pay_idx == (lpp_q - 16'd3));

        rate_in = (injection_rate > 8'd100) ? 8'd100 : injection_rate;
        if (lines_per_pkt < 16'd3) begin
            lpp_in = 16'd3;
        end else if (lines_per_pkt > LPP_MAX) begin
            lpp_in = LPP_MAX;
        end else begin
            lpp_in = lines_per_pkt;
        end

        lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

        case (patt_q)
            8'h55:   dst_next = lfsr & NODE_MASK;
            8'h4E:   dst_next = (NODE_ID + 16'd1) & NODE_MASK;
            8'h42:   dst_next = ~NODE_ID & NODE_MASK;
            default: dst_next = NODE_ID;
        endcase

        lpp_bytes = lpp_q << 3;
        hdr_line  = {2'b00, 1'b1, 1'b0, seqnum, lpp_bytes, NODE_ID, dst_next};
        pay_line  = {48'd0, pay_idx};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            m_axis_tdata   <= '0;
            m_axis_tlast   <= 1'b0;
            m_axis_tvalid  <= 1'b0;
            session_active <= 1'b0;
            xfer_count     <= 32'd0;
            pkt_count      <= 32'd0;
            seqnum         <= 12'd0;
            acc            <= 8'd0;
            lfsr           <= LFSR_SEED;
            ts             <= '0;
            pay_idx        <= 16'd0;
            hdr_out        <= 1'b0;
            stop_pend      <= 1'b0;
            rate_q         <= 8'd0;
            lpp_q          <= 16'd3;
            patt_q         <= 8'd0;
            num_pkts_q     <= 32'd0;
        end else begin
            if (hs) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                hdr_out       <= 1'b0;
                xfer_count    <= xfer_count + 32'd1;
            end
            if (last_hs) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (hs && hdr_out) begin
                ts   <= current_time;
                lfsr <= lfsr_step;
            end
            if (stop_stb && session_active) begin
                stop_pend <= 1'b1;
            end
            if (state != S_IDLE) begin
                acc <= acc_next;
            end

            case (state)
                S_IDLE: begin
                    if (start_stb) begin
                        state          <= S_HDR;
                        session_active <= 1'b1;
                        xfer_count     <= 32'd0;
                        pkt_count      <= 32'd0;
                        seqnum         <= 12'd0;
                        acc            <= 8'd0;
                        stop_pend      <= 1'b0;
                        rate_q         <= rate_in;
                        lpp_q          <= lpp_in;
                        patt_q         <= traffic_patt;
                        num_pkts_q     <= num_pkts;
                    end
                end
                S_HDR: begin
                    if (ending || idle_stop) begin
                        state          <= S_IDLE;
                        session_active <= 1'b0;
                        stop_pend      <= 1'b0;
                    end else if (can_load && credit_ok) begin
                        m_axis_tdata  <= hdr_line;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        hdr_out       <= 1'b1;
                        seqnum        <= seqnum + 12'd1;
                        state         <= S_TIME;
                    end
                end
                S_TIME: begin
                    if (can_load && credit_ok) begin
                        // Header accepted this very cycle: ts is not yet updated.
                        m_axis_tdata  <= (hs && hdr_out) ? current_time : ts;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        pay_idx       <= 16'd0;
                        state         <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (can_load && credit_ok) begin
                        m_axis_tdata  <= pay_line;
                        m_axis_tlast  <= last_pay;
                        m_axis_tvalid <= 1'b1;
                        pay_idx       <= pay_idx + 16'd1;
                        if (last_pay) begin
                            state <= S_HDR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chdr_traffic_source.sv
// Self-checking bench for chdr_traffic_source. A negedge monitor parses the
// output stream packet by packet against a model built from the packet rules
// (expected header/time/payload lines, destination pattern, credit pacing,
// AXI hold while stalled). Sessions are driven from a table of calls.
module tb_chdr_traffic_source;

    localparam logic [15:0] NODE = 16'd3;
    localparam logic [15:0] SEED = NODE ^ 16'hACE1;

    logic        clk;
    logic        rst_n;
    logic [63:0] current_time;
    logic        start_stb;
    logic [31:0] num_pkts;
    logic        stop_stb;
    logic [7:0]  injection_rate;
    logic [15:0] lines_per_pkt;
    logic [7:0]  traffic_patt;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        session_active;
    logic [31:0] xfer_count;
    logic [31:0] pkt_count;

    chdr_traffic_source #(
        .WIDTH(64), .MTU(5), .NODE_ID(NODE), .NUM_NODES(16'd16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .current_time(current_time),
        .start_stb(start_stb), .num_pkts(num_pkts), .stop_stb(stop_stb),
        .injection_rate(injection_rate), .lines_per_pkt(lines_per_pkt),
        .traffic_patt(traffic_patt), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .session_active(session_active),
        .xfer_count(xfer_count), .pkt_count(pkt_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] exp_dst(input logic [7:0] p, input logic [15:0] lf);
        case (p)
            "U":     return lf & 16'h000F;
            "N":     return (NODE + 16'd1) & 16'h000F;
            "B":     return ~NODE & 16'h000F;
            default: return NODE;
        endcase
    endfunction

    // session model parameters, written by the stimulus process only
    int         s_rate = 0;
    int         s_lpp = 3;
    logic [7:0] s_patt = "L";
    int         stall_pct = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        current_time  = 64'h1000;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            current_time  = {$urandom, $urandom};
            m_axis_tready = (int'($urandom_range(99)) >= stall_pct);
        end
    end

    // ---------------- monitor / reference model ----------------
    logic [15:0] m_lfsr = SEED;
    logic [11:0] exp_seq = 12'd0;
    logic [63:0] ts_exp = 64'd0;
    logic [63:0] prev_data = 64'd0;
    logic [15:0] d;
    logic        prev_last = 1'b0, prev_stall = 1'b0, prev_hs = 1'b0;
    logic        prev_valid = 1'b0, sa_prev = 1'b0;
    int          line_idx = 0, xfers_seen = 0, pkts_seen = 0, cyc = 0;
    int          first_hs = -1, last_hs = -1, sa_cycles = 0, valid_cycles = 0, acc_m = 0;
    int          hist[16];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_lfsr     = SEED;
            line_idx   = 0;
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
            prev_valid = 1'b0;
            sa_prev    = 1'b0;
            acc_m      = 0;
        end else begin
            if (start_stb && !session_active) begin
                xfers_seen = 0; pkts_seen = 0; exp_seq = 12'd0; line_idx = 0;
                sa_cycles = 0; valid_cycles = 0; first_hs = -1; last_hs = -1;
                foreach (hist[i]) hist[i] = 0;
            end
            if (prev_stall) begin
                chk("stall_valid", m_axis_tvalid, 1'b1);
                chk("stall_data", m_axis_tdata, prev_data);
                chk("stall_last", m_axis_tlast, prev_last);
            end
            if (session_active) begin
                sa_cycles++;
                if (!sa_prev) begin
                    acc_m = 0;
                end else begin
                    acc_m = acc_m + s_rate - (prev_hs ? 100 : 0);
                    if (acc_m > 200) acc_m = 200;
                end
                if (m_axis_tvalid && (!prev_valid || prev_hs))
                    chk("credit", (acc_m >= 100), 1'b1);
            end
            if (m_axis_tvalid) valid_cycles++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                xfers_seen++;
                if (line_idx == 0) begin
                    d = exp_dst(s_patt, m_lfsr);
                    chk("header", m_axis_tdata, {4'b0010, exp_seq, 16'(s_lpp * 8), NODE, d});
                    hist[d[3:0]]++;
                    m_lfsr = lfsr_next(m_lfsr);
                    ts_exp = current_time;
                end else if (line_idx == 1) begin
                    chk("timestamp", m_axis_tdata, ts_exp);
                end else begin
                    chk("payload", m_axis_tdata, 64'(line_idx - 2));
                end
                chk("tlast", m_axis_tlast, (line_idx == s_lpp - 1));
                line_idx++;
                if (line_idx == s_lpp) begin
                    line_idx = 0;
                    pkts_seen++;
                    exp_seq = exp_seq + 12'd1;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_hs    = m_axis_tvalid && m_axis_tready;
            prev_valid = m_axis_tvalid;
            sa_prev    = session_active;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_session(input int rate, input int lpp, input logic [7:0] patt,
                               input int npk, input int stall, input int stop_at,
                               input int stop_delay, input int exp_pkts, input int budget,
                               output int cycles);
        int  n;
        bit  stopped;
        s_rate    = (rate > 100) ? 100 : rate;
        s_lpp     = (lpp < 3) ? 3 : ((lpp > 32) ? 32 : lpp);
        s_patt    = patt;
        stall_pct = stall;
        injection_rate = rate[7:0];
        lines_per_pkt  = lpp[15:0];
        traffic_patt   = patt;
        num_pkts       = npk;
        @(posedge clk); #1 start_stb = 1'b1;
        @(posedge clk); #1 start_stb = 1'b0;
        // settings are latched at start; these must have no effect
        injection_rate = 8'($urandom);
        lines_per_pkt  = 16'($urandom);
        traffic_patt   = 8'($urandom);
        num_pkts       = $urandom;
        n = 0;
        stopped = 1'b0;
        while (session_active && n < budget) begin
            if (!stopped && stop_at >= 0 && n >= stop_delay && xfers_seen >= stop_at) begin
                stop_stb = 1'b1;
                stopped  = 1'b1;
            end else begin
                stop_stb = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        stop_stb  = 1'b0;
        stall_pct = 0;
        cycles    = n;
        chk("session_timeout", session_active, 1'b0);
        @(negedge clk);
        chk("pkts_seen", pkts_seen, exp_pkts);
        chk("pkt_count", pkt_count, exp_pkts);
        chk("xfer_count", xfer_count, exp_pkts * s_lpp);
        chk("xfers_seen", xfers_seen, exp_pkts * s_lpp);
        chk("partial_pkt", line_idx, 0);
        chk("tvalid_after", m_axis_tvalid, 1'b0);
        if (session_active) begin
            rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
        end
    endtask

    initial begin
        int cyc_used;
        int hits;
        int n;
        rst_n = 1'b0; start_stb = 1'b0; stop_stb = 1'b0; num_pkts = 0;
        injection_rate = 8'd0; lines_per_pkt = 16'd3; traffic_patt = "L";
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_active", session_active, 1'b0);
        chk("rst_xfer", xfer_count, 32'd0);
        chk("rst_pkt", pkt_count, 32'd0);

        run_session(100, 4, "L", 3, 0, -1, 0, 3, 200, cyc_used);
        chk("b2b_span", last_hs - first_hs, 11);

        run_session(50, 10, "N", 10, 0, -1, 0, 10, 400, cyc_used);
        chk("rate50_duration", (sa_cycles >= 198 && sa_cycles <= 202), 1'b1);

        run_session(200, 3, "B", 5, 0, -1, 0, 5, 200, cyc_used);
        run_session(77, 2, "X", 4, 0, -1, 0, 4, 200, cyc_used);
        run_session(100, 100, "U", 3, 30, -1, 0, 3, 2000, cyc_used);
        run_session(100, 7, "L", 40, 30, -1, 0, 40, 2000, cyc_used);

        run_session(100, 3, "U", 1000, 0, -1, 0, 1000, 4000, cyc_used);
        hits = 0;
        for (int i = 0; i < 16; i++) if (hist[i] > 0) hits++;
        chk("u_dst_cover", hits, 16);

        // stop while line 26 of a 10-line packet is on the bus -> 3 packets
        run_session(100, 10, "L", 0, 0, 25, 0, 3, 400, cyc_used);

        // no traffic at rate 0; stop ends the session on the next cycle
        run_session(0, 5, "L", 0, 0, 0, 40, 0, 200, cyc_used);
        chk("idle_stop_latency", cyc_used, 41);
        chk("no_traffic", valid_cycles, 0);

        // seqnum wraps 4095 -> 0 (4101 packets)
        run_session(100, 3, "N", 0, 0, 12300, 0, 4101, 14000, cyc_used);

        // reset in the middle of a payload
        s_rate = 100; s_lpp = 10; s_patt = "U"; stall_pct = 0;
        injection_rate = 8'd100; lines_per_pkt = 16'd10; traffic_patt = "U"; num_pkts = 5;
        @(posedge clk); #1 start_stb = 1'b1;
        @(posedge clk); #1 start_stb = 1'b0;
        n = 0;
        while (xfers_seen < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_reach", (xfers_seen >= 4), 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_xfer", xfer_count, 32'd0);
        chk("mid_rst_pkt", pkt_count, 32'd0);
        chk("mid_rst_active", session_active, 1'b0);
        run_session(100, 5, "U", 2, 0, -1, 0, 2, 200, cyc_used);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
